ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. The CPU writes one command byte over the same STB/ACK slave bus used by the keyboard read path; examples are 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset).
- The block inhibits the bus, frames the byte (start, 8 data bits LSB first, odd parity, stop), then checks the device's line-ACK bit.
- Drives open-drain PS/2 clock/data through active-high pull-low enables. Sits beside the keyboard receive driver and reports tx_busy so the receive path ignores the line during transmission.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_sync.sv | 43 ++++
 rtl/ps2_host_tx.sv | 237 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its receive-side neighbours.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } tx_state_e;

  localparam int STAT_BUSY = 8;
  localparam int STAT_NACK = 9;
  localparam int STAT_TOUT = 10;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  localparam int MAX_RETRIES = 2;

  // Serial order is bit 0 first: D0..D7, odd parity, stop.
  function automatic logic [9:0] build_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the raw PS/2 clock/data lines plus a registered
// falling-edge pulse on the synchronised clock. Lines reset high (bus idle).
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic sync_clk_o,
  output logic sync_data_o,
  output logic fall_o
);

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_prev_q, clk_prev_d;
  logic       fall_q, fall_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
    data_sync_d = {data_sync_q[0], ps2_data_i};
    clk_prev_d  = clk_sync_q[1];
    fall_d      = clk_prev_q & ~clk_sync_q[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      fall_q      <= fall_d;
    end
  end

  assign sync_clk_o  = clk_sync_q[1];
  assign sync_data_o = data_sync_q[1];
  assign fall_o      = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter behind an STB/ACK slave port.
// Optional macro PS2_HOST_TX_RESEND_EN: retry a NACKed byte up to MAX_RETRIES times.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | lines released, waiting for a command write
// ST_INHIBIT   | clock held low; data pulled low in the last cycle (start)
// ST_RELEASE   | clock released, start bit on data, timeout armed
// ST_SHIFT     | each device clock fall drives the next frame bit
// ST_WAIT_ACK  | lines released, sample device line-ACK on next fall
// ST_WAIT_IDLE | wait for synchronised clock and data both high
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] DAT_I,
  output logic        ACK,
  output logic [31:0] DAT_O,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_pull,
  output logic        ps2_data_pull,
  output logic        tx_busy
);

  localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);
  localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0]  INH_LOAD  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TOUT_W-1:0] TOUT_LOAD = TOUT_W'(TIMEOUT_CYCLES - 1);

  tx_state_e         state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic [9:0]        frame_q, frame_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d;
  logic [TOUT_W-1:0] tout_cnt_q, tout_cnt_d;
  logic              clk_pull_q, clk_pull_d;
  logic              data_pull_q, data_pull_d;
  logic              nack_err_q, nack_err_d;
  logic              tout_err_q, tout_err_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_o_q, dat_o_d;
`ifdef PS2_HOST_TX_RESEND_EN
  logic [1:0]        retry_q, retry_d;
`endif

  logic        sync_clk, sync_data, fall;
  logic        busy, rd_req, wr_accept, running;
  logic [31:0] status;
  logic        unused_dat_hi;

  assign unused_dat_hi = ^DAT_I[31:8];

  ps2_line_sync u_sync (
    .clk         (clk),
    .rst         (reset),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .sync_clk_o  (sync_clk),
    .sync_data_o (sync_data),
    .fall_o      (fall)
  );

  assign busy      = (state_q != ST_IDLE);
  assign rd_req    = STB & ~WE;
  assign wr_accept = STB & WE & (state_q == ST_IDLE);
  assign running   = (state_q == ST_RELEASE) || (state_q == ST_SHIFT) ||
                     (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_IDLE);

  always_comb begin
    status            = '0;
    status[7:0]       = byte_q;
    status[STAT_BUSY] = busy;
    status[STAT_NACK] = nack_err_q;
    status[STAT_TOUT] = tout_err_q;
  end

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    inh_cnt_d   = inh_cnt_q;
    tout_cnt_d  = tout_cnt_q;
    clk_pull_d  = clk_pull_q;
    data_pull_d = data_pull_q;
    nack_err_d  = nack_err_q;
    tout_err_d  = tout_err_q;
`ifdef PS2_HOST_TX_RESEND_EN
    retry_d     = retry_q;
`endif
    ack_d       = STB;
    dat_o_d     = rd_req ? status : 32'h0;

    // Read-to-clear happens first so a flag raised in the same cycle survives.
    if (rd_req) begin
      nack_err_d = 1'b0;
      tout_err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        clk_pull_d  = 1'b0;
        data_pull_d = 1'b0;
        if (wr_accept) begin
          byte_d     = DAT_I[7:0];
          frame_d    = build_frame(DAT_I[7:0]);
          nack_err_d = 1'b0;
          tout_err_d = 1'b0;
          inh_cnt_d  = INH_LOAD;
          clk_pull_d = 1'b1;
          state_d    = ST_INHIBIT;
`ifdef PS2_HOST_TX_RESEND_EN
          retry_d    = 2'd0;
`endif
        end
      end
      ST_INHIBIT: begin
        clk_pull_d = 1'b1;
        if (inh_cnt_q == INH_W'(1)) data_pull_d = 1'b1;
        if (inh_cnt_q == '0) begin
          clk_pull_d  = 1'b0;
          data_pull_d = 1'b1;
          bit_cnt_d   = 4'd0;
          tout_cnt_d  = TOUT_LOAD;
          state_d     = ST_RELEASE;
        end else begin
          inh_cnt_d = inh_cnt_q - INH_W'(1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (fall) begin
          data_pull_d = ~frame_q[0];
          frame_d     = {1'b0, frame_q[9:1]};
          bit_cnt_d   = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (fall) begin
          if (!sync_data) begin
            state_d = ST_WAIT_IDLE;
          end else begin
`ifdef PS2_HOST_TX_RESEND_EN
            if (retry_q < 2'(MAX_RETRIES)) begin
              retry_d     = retry_q + 2'd1;
              frame_d     = build_frame(byte_q);
              inh_cnt_d   = INH_LOAD;
              clk_pull_d  = 1'b1;
              data_pull_d = 1'b0;
              state_d     = ST_INHIBIT;
            end else begin
              nack_err_d = 1'b1;
              state_d    = ST_WAIT_IDLE;
            end
`else
            nack_err_d = 1'b1;
            state_d    = ST_WAIT_IDLE;
`endif
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (sync_clk && sync_data) state_d = ST_IDLE;
      end
      default: begin
        clk_pull_d  = 1'b0;
        data_pull_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    // Timeout overrides whatever the frame logic decided this cycle.
    if (running) begin
      if (tout_cnt_q == '0) begin
        tout_err_d  = 1'b1;
        clk_pull_d  = 1'b0;
        data_pull_d = 1'b0;
        state_d     = ST_IDLE;
      end else begin
        tout_cnt_d = tout_cnt_q - TOUT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      byte_q      <= 8'h00;
      frame_q     <= 10'h000;
      bit_cnt_q   <= 4'd0;
      inh_cnt_q   <= '0;
      tout_cnt_q  <= '0;
      clk_pull_q  <= 1'b0;
      data_pull_q <= 1'b0;
      nack_err_q  <= 1'b0;
      tout_err_q  <= 1'b0;
      ack_q       <= 1'b0;
      dat_o_q     <= 32'h0;
`ifdef PS2_HOST_TX_RESEND_EN
      retry_q     <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      inh_cnt_q   <= inh_cnt_d;
      tout_cnt_q  <= tout_cnt_d;
      clk_pull_q  <= clk_pull_d;
      data_pull_q <= data_pull_d;
      nack_err_q  <= nack_err_d;
      tout_err_q  <= tout_err_d;
      ack_q       <= ack_d;
      dat_o_q     <= dat_o_d;
`ifdef PS2_HOST_TX_RESEND_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign ACK           = ack_q;
  assign DAT_O         = dat_o_q;
  assign ps2_clk_pull  = clk_pull_q;
  assign ps2_data_pull = data_pull_q;
  assign tx_busy       = busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 200;
  localparam int TOUT = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        STB = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] DAT_I = 32'h0;
  logic        ACK;
  logic [31:0] DAT_O;
  logic        ps2_clk_pull, ps2_data_pull, tx_busy;
  logic        ps2_clk_i, ps2_data_i;
  logic        dev_clk_pull = 1'b0;
  logic        dev_data_pull = 1'b0;

  assign ps2_clk_i  = ~(ps2_clk_pull | dev_clk_pull);
  assign ps2_data_i = ~(ps2_data_pull | dev_data_pull);

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_bus_q[$];
  logic [9:0]  exp_frame_q[$];
  int          exp_inh_q[$];
  int          dev_fall_cnt = 0;
  logic [9:0]  obs_frame;
  event        frame_ev;
  int          inh_run = 0;
  time         t0, t1;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset), .STB(STB), .WE(WE), .DAT_I(DAT_I),
    .ACK(ACK), .DAT_O(DAT_O),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_pull(ps2_clk_pull), .ps2_data_pull(ps2_data_pull),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Bus monitor: every ACK pops one expected DAT_O.
  initial forever begin
    @(negedge clk);
    if (ACK === 1'b1) begin
      if (exp_bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected_ack: got DAT_O 0x%08h, expected no ACK", DAT_O);
      end else begin
        chk("bus_dat_o", DAT_O, exp_bus_q.pop_front());
      end
    end
  end

  // Inhibit monitor: length of each clock-pull run.
  initial forever begin
    @(negedge clk);
    if (ps2_clk_pull === 1'b1) begin
      inh_run++;
    end else if (inh_run > 0) begin
      if (exp_inh_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL inhibit_unexpected: got %0d cycles, expected none", inh_run);
      end else begin
        chk("inhibit_len", inh_run, exp_inh_q.pop_front());
      end
      inh_run = 0;
    end
  end

  // Frame monitor: device-captured bits against the expected frame.
  initial forever begin
    @(frame_ev);
    if (exp_frame_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_unexpected: got 0x%03h, expected none", obs_frame);
    end else begin
      chk("frame_bits", {22'h0, obs_frame}, {22'h0, exp_frame_q.pop_front()});
    end
  end

  task automatic bus_op(input logic we, input logic [31:0] d, input logic [31:0] exp);
    @(posedge clk); #1;
    STB = 1'b1; WE = we; DAT_I = d;
    exp_bus_q.push_back(exp);
    @(posedge clk); #1;
    STB = 1'b0; WE = 1'b0; DAT_I = 32'h0;
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while (tx_busy === 1'b1 && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk("busy_idle", {31'h0, tx_busy}, 32'h0);
  endtask

  task automatic wait_falls(input int n);
    int t;
    t = 0;
    while (dev_fall_cnt < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (dev_fall_cnt < n) bound_fail("wait_falls");
  endtask

  // Device: waits for release with start bit, clocks n_falls bits (40-cycle period),
  // samples mid-low, then on a full frame answers with the line-ACK bit.
  task automatic dev_frame(input int n_falls, input logic nack);
    int t;
    logic [9:0] bits;
    bits = '0;
    dev_fall_cnt = 0;
    t = 0;
    while (!(ps2_clk_pull === 1'b0 && ps2_data_pull === 1'b1 && tx_busy === 1'b1) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      bound_fail("dev_wait_release");
      return;
    end
    repeat (10) @(negedge clk);
    chk("start_bit_line", {31'h0, ps2_data_i}, 32'h0);
    for (int i = 0; i < n_falls; i++) begin
      dev_clk_pull = 1'b1;
      dev_fall_cnt = i + 1;
      repeat (15) @(negedge clk);
      bits[i] = ps2_data_i;
      repeat (5) @(negedge clk);
      dev_clk_pull = 1'b0;
      repeat (20) @(negedge clk);
    end
    if (n_falls == 10) begin
      obs_frame = bits;
      -> frame_ev;
      dev_data_pull = ~nack;
      repeat (5) @(negedge clk);
      dev_clk_pull = 1'b1;
      repeat (20) @(negedge clk);
      chk("busy_before_idle", {31'h0, tx_busy}, 32'h1);
      if (!nack) chk("pulls_after_ack", {30'h0, ps2_clk_pull, ps2_data_pull}, 32'h0);
      dev_clk_pull = 1'b0;
      dev_data_pull = 1'b0;
      repeat (20) @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_nack;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'h0, ACK}, 32'h0);
    chk("rst_dat_o", DAT_O, 32'h0);
    chk("rst_pulls", {30'h0, ps2_clk_pull, ps2_data_pull}, 32'h0);
    chk("rst_busy", {31'h0, tx_busy}, 32'h0);
    reset = 1'b0;
    bus_op(1'b0, 32'h0, 32'h0000_0000);

    // 0xED, device ACKs
    exp_inh_q.push_back(INH);
    exp_frame_q.push_back(10'h3ED);
    bus_op(1'b1, {24'h0, CMD_SET_LED}, 32'h0);
    dev_frame(10, 1'b0);
    wait_idle(2000);
    bus_op(1'b0, 32'h0, 32'h0000_00ED);

    // 0xF4, parity 0
    exp_inh_q.push_back(INH);
    exp_frame_q.push_back(10'h2F4);
    bus_op(1'b1, {24'h0, CMD_ENABLE}, 32'h0);
    dev_frame(10, 1'b0);
    wait_idle(2000);
    bus_op(1'b0, 32'h0, 32'h0000_00F4);

    // 0x12, device NACKs every attempt
`ifdef PS2_HOST_TX_RESEND_EN
    n_nack = 3;
`else
    n_nack = 1;
`endif
    for (int i = 0; i < n_nack; i++) begin
      exp_inh_q.push_back(INH);
      exp_frame_q.push_back(10'h312);
    end
    bus_op(1'b1, 32'h0000_0012, 32'h0);
    for (int i = 0; i < n_nack; i++) dev_frame(10, 1'b1);
    wait_idle(2000);
    bus_op(1'b0, 32'h0, 32'h0000_0212);
    bus_op(1'b0, 32'h0, 32'h0000_0012);

    // 0x55, device silent -> timeout
    exp_inh_q.push_back(INH);
    bus_op(1'b1, 32'h0000_0055, 32'h0);
    begin
      int t;
      t = 0;
      while (!(ps2_clk_pull === 1'b0 && ps2_data_pull === 1'b1) && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) bound_fail("timeout_release");
      t0 = $time;
      t = 0;
      while (tx_busy === 1'b1 && t < TOUT + 200) begin
        @(negedge clk);
        t++;
      end
      t1 = $time;
    end
    chk("timeout_cycles", 32'((t1 - t0) / 10), TOUT);
    chk("timeout_pulls", {30'h0, ps2_clk_pull, ps2_data_pull}, 32'h0);
    chk("timeout_busy", {31'h0, tx_busy}, 32'h0);
    bus_op(1'b0, 32'h0, 32'h0000_0455);
    bus_op(1'b0, 32'h0, 32'h0000_0055);

    // 0xA5 with a 0xFF write dropped mid-frame
    exp_inh_q.push_back(INH);
    exp_frame_q.push_back(10'h3A5);
    bus_op(1'b1, 32'h0000_00A5, 32'h0);
    fork
      dev_frame(10, 1'b0);
      begin
        wait_falls(3);
        bus_op(1'b1, {24'h0, CMD_RESET}, 32'h0);
      end
    join
    wait_idle(2000);
    bus_op(1'b0, 32'h0, 32'h0000_00A5);

    // 0x00, async reset at fall 5
    exp_inh_q.push_back(INH);
    bus_op(1'b1, 32'h0000_0000, 32'h0);
    fork
      dev_frame(5, 1'b0);
      begin
        wait_falls(5);
        repeat (8) @(posedge clk);
        #2;
        chk("data_pull_bit4", {31'h0, ps2_data_pull}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_mid_pulls", {30'h0, ps2_clk_pull, ps2_data_pull}, 32'h0);
        chk("rst_mid_busy", {31'h0, tx_busy}, 32'h0);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // fresh write after reset
    exp_inh_q.push_back(INH);
    exp_frame_q.push_back(10'h2F4);
    bus_op(1'b1, {24'h0, CMD_ENABLE}, 32'h0);
    dev_frame(10, 1'b0);
    wait_idle(2000);
    bus_op(1'b0, 32'h0, 32'h0000_00F4);

    repeat (5) @(negedge clk);
    chk("bus_q_drained", exp_bus_q.size(), 32'h0);
    chk("frame_q_drained", exp_frame_q.size(), 32'h0);
    chk("inh_q_drained", exp_inh_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
